// File: rtl/opmem_pkg.sv
// ---------------------------------------------------------------------------
// opmem_pkg
// Shared constants and address-map helpers for the operand register file.
// Address map: 0..depth-1 are general operand words, depth is the A_C curve
// constant, depth+1 is the C_C curve constant, anything above is out of range.
// ---------------------------------------------------------------------------
package opmem_pkg;

   localparam int OPMEM_WIDTH  = 40;
   localparam int OPMEM_DEPTH  = 64;
   localparam int OPMEM_ADDR_W = 7;

   // Address of the A_C curve-constant register
   function automatic int unsigned addr_a_c(input int unsigned depth);
      return depth;
   endfunction

   // Address of the C_C curve-constant register
   function automatic int unsigned addr_c_c(input int unsigned depth);
      return depth + 1;
   endfunction

   // Full-width compare so large addresses can never alias onto a stored word
   function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
      return addr <= addr_c_c(depth);
   endfunction

endpackage

// File: rtl/opmem_rd_port.sv
// ---------------------------------------------------------------------------
// opmem_rd_port
// One registered read port of the operand register file: address decode,
// write-to-read bypass compare, and the data/valid/error output registers.
//
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   rd_en      read request for this port
//   rd_addr    read address
//   wr_en      write strobe of the shared write port (for bypass)
//   wr_addr    write address of the shared write port (for bypass)
//   wr_data    write data of the shared write port (for bypass)
//   words      current contents of all DEPTH+2 storage words
//   rd_data    registered read data, held while no read is requested
//   rd_valid   high one cycle after rd_en
//   rd_err     high with rd_valid when the address was out of range
// ---------------------------------------------------------------------------
module opmem_rd_port
   import opmem_pkg::*;
#(
   parameter int WIDTH  = OPMEM_WIDTH,
   parameter int DEPTH  = OPMEM_DEPTH,
   parameter int ADDR_W = OPMEM_ADDR_W
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         rd_en,
   input  logic [ADDR_W-1:0]            rd_addr,
   input  logic                         wr_en,
   input  logic [ADDR_W-1:0]            wr_addr,
   input  logic [WIDTH-1:0]             wr_data,
   input  logic [DEPTH+1:0][WIDTH-1:0]  words,
   output logic [WIDTH-1:0]             rd_data,
   output logic                         rd_valid,
   output logic                         rd_err
);

   logic             in_range;
   logic             bypass;
   logic [WIDTH-1:0] next_data;

   // Decode the request. A same-cycle write to the same address wins over the
   // stored word so the reader sees the new value. The in_range term also
   // guarantees the bypass only fires for writes that actually land.
   always_comb begin
      in_range  = addr_in_range(32'(rd_addr), DEPTH);
      bypass    = wr_en && (wr_addr == rd_addr) && in_range;
      next_data = '0;
      if (bypass) begin
         next_data = wr_data;
      end else if (in_range) begin
         next_data = words[rd_addr];
      end
   end

   // Output registers. Data only moves on a request so consumers can keep
   // using the last operand; valid and err are strictly one-cycle pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
         rd_err   <= 1'b0;
      end else if (rd_en) begin
         rd_data  <= next_data;
         rd_valid <= 1'b1;
         rd_err   <= ~in_range;
      end else begin
         rd_valid <= 1'b0;
         rd_err   <= 1'b0;
      end
   end

endmodule

// File: rtl/operand_regfile.sv
// ---------------------------------------------------------------------------
// operand_regfile
// Operand storage for the field-arithmetic datapath: DEPTH general words plus
// the A_C and C_C curve constants, one write port and NUM_RD independent
// registered read ports with bypass and out-of-range flags.
//
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   wr_en      write strobe
//   wr_addr    write address (0..DEPTH+1 valid)
//   wr_data    write data
//   rd_en      per-port read request
//   rd_addr    packed read addresses, port p at [p*ADDR_W +: ADDR_W]
//   rd_data    packed read data, port p at [p*WIDTH +: WIDTH]
//   rd_valid   per-port data valid, one cycle after rd_en
//   rd_err     per-port out-of-range flag, aligned with rd_valid
//   wr_err     previous cycle's write was out of range
// ---------------------------------------------------------------------------
module operand_regfile
   import opmem_pkg::*;
#(
   parameter int WIDTH  = OPMEM_WIDTH,
   parameter int DEPTH  = OPMEM_DEPTH,
   parameter int ADDR_W = OPMEM_ADDR_W,
   parameter int NUM_RD = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_en,
   input  logic [ADDR_W-1:0]          wr_addr,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic [NUM_RD-1:0]          rd_en,
   input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
   output logic [NUM_RD*WIDTH-1:0]    rd_data,
   output logic [NUM_RD-1:0]          rd_valid,
   output logic [NUM_RD-1:0]          rd_err,
   output logic                       wr_err
);

   logic [DEPTH+1:0][WIDTH-1:0] mem;
   logic                        wr_in_range;

   // Out-of-range writes are discarded rather than wrapped onto a real word
   always_comb begin
      wr_in_range = addr_in_range(32'(wr_addr), DEPTH);
   end

   // Storage and write-error flag. Reset clears the curve constants too, so
   // the sequencer must reload A_C and C_C after every reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem    <= '0;
         wr_err <= 1'b0;
      end else begin
         if (wr_en && wr_in_range) begin
            mem[wr_addr] <= wr_data;
         end
         wr_err <= wr_en && !wr_in_range;
      end
   end

   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd_port
      opmem_rd_port #(
         .WIDTH  (WIDTH),
         .DEPTH  (DEPTH),
         .ADDR_W (ADDR_W)
      ) u_rd_port (
         .clk      (clk),
         .rst      (rst),
         .rd_en    (rd_en[p]),
         .rd_addr  (rd_addr[p*ADDR_W +: ADDR_W]),
         .wr_en    (wr_en),
         .wr_addr  (wr_addr),
         .wr_data  (wr_data),
         .words    (mem),
         .rd_data  (rd_data[p*WIDTH +: WIDTH]),
         .rd_valid (rd_valid[p]),
         .rd_err   (rd_err[p])
      );
   end

endmodule

// File: tb/tb_operand_regfile.sv
// ---------------------------------------------------------------------------
// tb_operand_regfile
// Drives directed and randomized traffic into operand_regfile. A reference
// memory model computes every cycle's expected outputs, which are queued and
// compared by an independent monitor on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_operand_regfile;

   localparam int WIDTH  = 40;
   localparam int DEPTH  = 64;
   localparam int ADDR_W = 7;
   localparam int NUM_RD = 2;
   localparam int NWORDS = DEPTH + 2;

   logic                     clk = 1'b0;
   logic                     rst;
   logic                     wr_en;
   logic [ADDR_W-1:0]        wr_addr;
   logic [WIDTH-1:0]         wr_data;
   logic [NUM_RD-1:0]        rd_en;
   logic [NUM_RD*ADDR_W-1:0] rd_addr;
   logic [NUM_RD*WIDTH-1:0]  rd_data;
   logic [NUM_RD-1:0]        rd_valid;
   logic [NUM_RD-1:0]        rd_err;
   logic                     wr_err;

   typedef struct packed {
      logic                         wr_err;
      logic [NUM_RD-1:0]            valid;
      logic [NUM_RD-1:0]            err;
      logic [NUM_RD-1:0][WIDTH-1:0] data;
   } exp_t;

   exp_t             exp_q[$];
   logic [WIDTH-1:0] model_mem [NWORDS];
   logic [WIDTH-1:0] last_data [NUM_RD];
   int               checks   = 0;
   int               failures = 0;

   // Free-running clock
   always #5 clk = ~clk;

   operand_regfile #(
      .WIDTH  (WIDTH),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .NUM_RD (NUM_RD)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_en    (rd_en),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .rd_err   (rd_err),
      .wr_err   (wr_err)
   );

   // Single comparison point so every check is counted the same way
   task automatic checkOutput(input string name, input logic [WIDTH-1:0] act,
                              input logic [WIDTH-1:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // Drive one cycle of inputs and predict the outputs after the next edge.
   // The model applies the write before the reads, which is what gives
   // same-cycle readers the newly written word.
   task automatic applyStimulus(input logic r, input logic we, input logic [ADDR_W-1:0] wa,
                                input logic [WIDTH-1:0] wd, input logic [NUM_RD-1:0] re,
                                input logic [ADDR_W-1:0] ra0, input logic [ADDR_W-1:0] ra1);
      exp_t              e;
      logic [ADDR_W-1:0] ra;
      rst     = r;
      wr_en   = we;
      wr_addr = wa;
      wr_data = wd;
      rd_en   = re;
      rd_addr = {ra1, ra0};
      e = '0;
      if (r) begin
         for (int i = 0; i < NWORDS; i++) model_mem[i] = '0;
         for (int p = 0; p < NUM_RD; p++) last_data[p] = '0;
      end else begin
         if (we && int'(wa) < NWORDS) model_mem[wa] = wd;
         e.wr_err = we && int'(wa) >= NWORDS;
         for (int p = 0; p < NUM_RD; p++) begin
            ra = (p == 0) ? ra0 : ra1;
            if (re[p]) begin
               e.valid[p] = 1'b1;
               if (int'(ra) < NWORDS) begin
                  last_data[p] = model_mem[ra];
               end else begin
                  last_data[p] = '0;
                  e.err[p]     = 1'b1;
               end
            end
         end
      end
      for (int p = 0; p < NUM_RD; p++) e.data[p] = last_data[p];
      @(posedge clk);
      exp_q.push_back(e);
      #1;
   endtask

   // Mostly legal addresses, with occasional arbitrary 7-bit values
   function automatic logic [ADDR_W-1:0] randAddr();
      if ($urandom_range(0, 9) == 0) return ADDR_W'($urandom);
      return ADDR_W'($urandom_range(0, NWORDS - 1));
   endfunction

   // Monitor: one expected record per clocked cycle, compared mid-cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("wr_err", WIDTH'(wr_err), WIDTH'(e.wr_err));
            for (int p = 0; p < NUM_RD; p++) begin
               checkOutput($sformatf("rd_valid[%0d]", p), WIDTH'(rd_valid[p]), WIDTH'(e.valid[p]));
               checkOutput($sformatf("rd_err[%0d]", p), WIDTH'(rd_err[p]), WIDTH'(e.err[p]));
               checkOutput($sformatf("rd_data[%0d]", p), rd_data[p*WIDTH +: WIDTH], e.data[p]);
            end
         end
      end
   end

   // Stimulus sequence
   initial begin
      rst     = 1'b1;
      wr_en   = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      rd_en   = '0;
      rd_addr = '0;
      @(posedge clk);
      #1;

      // Requests during reset must be dropped
      applyStimulus(1, 1, 7'd5, 40'hDE_ADBE_EF00, 2'b11, 7'd5, 7'd5);
      applyStimulus(1, 0, 7'd0, 40'h0, 2'b11, 7'd0, 7'd1);

      // Fresh storage reads back zero, including both constants
      applyStimulus(0, 0, 7'd0, 40'h0, 2'b01, 7'd0, 7'd0);
      applyStimulus(0, 0, 7'd0, 40'h0, 2'b01, 7'd63, 7'd0);
      applyStimulus(0, 0, 7'd0, 40'h0, 2'b01, 7'd64, 7'd0);
      applyStimulus(0, 0, 7'd0, 40'h0, 2'b01, 7'd65, 7'd0);

      // Write then read the same word on both ports
      applyStimulus(0, 1, 7'd5, 40'h12_3456_789A, 2'b00, 7'd0, 7'd0);
      applyStimulus(0, 0, 7'd0, 40'h0, 2'b11, 7'd5, 7'd5);

      // Bypass into port 1 on the A_C register
      applyStimulus(0, 1, 7'd64, 40'hFF_FFFF_FFFF, 2'b10, 7'd0, 7'd64);

      // Out-of-range reads and write; the write must not wrap onto word 36
      applyStimulus(0, 1, 7'd100, 40'hAB_CDEF_0123, 2'b01, 7'd66, 7'd0);
      applyStimulus(0, 0, 7'd0, 40'h0, 2'b01, 7'd127, 7'd0);
      applyStimulus(0, 0, 7'd0, 40'h0, 2'b11, 7'd36, 7'd64);

      // Fill every word with its address, then stream reads back-to-back
      for (int n = 0; n < NWORDS; n++) applyStimulus(0, 1, ADDR_W'(n), WIDTH'(n), 2'b00, 7'd0, 7'd0);
      for (int n = 0; n < NWORDS; n++) applyStimulus(0, 0, 7'd0, 40'h0, 2'b01, ADDR_W'(n), 7'd0);

      // Randomized traffic with frequent write/read address collisions
      for (int i = 0; i < 400; i++) begin
         logic [ADDR_W-1:0] wa;
         logic [ADDR_W-1:0] a0;
         logic [ADDR_W-1:0] a1;
         wa = randAddr();
         a0 = randAddr();
         a1 = randAddr();
         if ($urandom_range(0, 3) == 0) a0 = wa;
         if ($urandom_range(0, 3) == 0) a1 = wa;
         applyStimulus(0, 1'($urandom_range(0, 1)), wa, {8'($urandom), 32'($urandom)},
                       2'($urandom), a0, a1);
      end

      // Reset in the middle of a stream, then confirm word 5 was cleared
      applyStimulus(0, 1, 7'd5, 40'h55_5555_5555, 2'b11, 7'd5, 7'd3);
      applyStimulus(1, 0, 7'd0, 40'h0, 2'b11, 7'd5, 7'd5);
      applyStimulus(0, 0, 7'd0, 40'h0, 2'b00, 7'd0, 7'd0);
      applyStimulus(0, 0, 7'd0, 40'h0, 2'b01, 7'd5, 7'd0);
      applyStimulus(0, 0, 7'd0, 40'h0, 2'b00, 7'd0, 7'd0);

      // Let the monitor drain the remaining expectations, with a bound
      for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
         @(negedge clk);
         #1;
      end
      if (exp_q.size() > 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
